binary_to_gray: RTL and testbench
=================================

Name: binary_to_gray

Overview:
- Registered, parameterised binary-to-Gray code converter.
- Each accepted binary sample is encoded as gray = bin XOR (bin >> 1) and presented one clock later with a valid strobe.
- A sequence monitor reports whether consecutive accepted codes differ in exactly one bit.
- Used where counters or pointers cross clock domains or drive status displays.

Parameters:
- WIDTH, 4, bit width of the binary input and Gray output; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- in_valid  input  1  bin_in is sampled on this rising edge when high.
- bin_in  input  WIDTH  binary value to convert.
- out_valid  output  1  high for one cycle per accepted sample.
- gray_out  output  WIDTH  registered Gray code of the last accepted sample.
- adj_ok  output  1  high when the current gray_out differs from the previous accepted code in exactly one bit.
- sample_cnt  output  WIDTH  count of accepted samples, modulo 2^WIDTH.

Behaviour:
- Reset (rst_n low, asynchronous): gray_out=0, out_valid=0, adj_ok=0, sample_cnt=0, internal have_prev=0, internal prev_gray=0.
- Encoding:
  - gray_out[WIDTH-1] = bin_in[WIDTH-1].
  - gray_out[i] = bin_in[i+1] XOR bin_in[i], for i < WIDTH-1.
  - Pure bitwise logic; no arithmetic carry.
- Latency:
  - A sample accepted at edge N appears on gray_out, with out_valid=1, after edge N.
  - Exactly 1 cycle of latency; full throughput of one sample per clock.
- in_valid low:
  - gray_out and adj_ok hold their last values.
  - out_valid=0 the following cycle.
  - sample_cnt holds.
- adj_ok, updated only on accepted samples:
  - First accepted sample after reset (have_prev=0): adj_ok=0, then have_prev is set to 1.
  - Later samples: adj_ok=1 iff the popcount of (new_gray XOR prev_gray) equals 1.
  - Identical consecutive samples give popcount 0, so adj_ok=0.
  - prev_gray is updated with new_gray on every accepted sample.
- Wrap-around:
  - bin 2^WIDTH-1 followed by 0 gives gray 100..0 then 000..0, one-bit difference, so adj_ok=1.
  - sample_cnt wraps silently from 2^WIDTH-1 to 0.
- Reset mid-stream:
  - All outputs clear immediately, independent of clk.
  - have_prev clears, so the next accepted sample reports adj_ok=0.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

Optional Feature:
- Macro GRAY_DECODE_CHECK_EN.
- When defined:
  - A registered inverse decoder reconstructs binary from gray_out: b[WIDTH-1] = g[WIDTH-1], b[i] = b[i+1] XOR g[i].
  - It compares the result against a registered copy of the accepted bin_in.
  - Extra output decode_err (1 bit, reset 0) pulses high for one cycle, coincident with out_valid, on any mismatch.
  - Extra output bin_echo (WIDTH) carries the decoded binary value.
- When undefined: decode_err and bin_echo ports are absent, no decoder logic is built, and all other behaviour is unchanged.

Test Plan:
- Reset then sweep bin_in 0..15 (WIDTH=4), in_valid=1 every cycle -> gray_out one cycle later: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; out_valid=1 throughout; adj_ok=0 on the first sample, 1 on all others; sample_cnt reaches 0 after 16 samples.
- After the sweep, bin_in=0 -> gray_out=0000, adj_ok=1 (1000 to 0000 wrap).
- bin_in=5 then 5 -> gray_out=0111 both times; adj_ok=0 on the second sample.
- bin_in=3 then 12 -> gray_out 0010 then 1010; adj_ok=1. bin_in=0 then 3 -> 0000 then 0010; adj_ok=1. bin_in=1 then 2 -> 0001 then 0011; adj_ok=1. bin_in=0 then 5 -> 0000 then 0111; adj_ok=0.
- in_valid low for 3 cycles after bin_in=9 -> gray_out holds 1101, out_valid=0, sample_cnt unchanged; assert rst_n low mid-cycle -> all outputs 0 immediately.
- With GRAY_DECODE_CHECK_EN: full 0..15 sweep -> bin_echo equals the input sequence and decode_err stays 0; force a gray_out bit flip -> decode_err=1 for one cycle.

Source files
------------

// File: rtl/binary_to_gray.sv
// Registered binary-to-Gray converter with a one-bit-change monitor on accepted codes.
// Define GRAY_DECODE_CHECK_EN to add an inverse decoder self-check (decode_err, bin_echo).
module binary_to_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] bin_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic             adj_ok,
  output logic [WIDTH-1:0] sample_cnt
`ifdef GRAY_DECODE_CHECK_EN
  ,
  output logic             decode_err,
  output logic [WIDTH-1:0] bin_echo
`endif
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] diff;
  logic             one_bit;
  logic             adj_d;
  logic             have_prev_q;
  logic [WIDTH-1:0] prev_gray_q;

  always_comb begin
    gray_d = '0;
    gray_d[WIDTH-1] = bin_in[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      gray_d[i] = bin_in[i+1] ^ bin_in[i];
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    diff    = gray_d ^ prev_gray_q;
    one_bit = (diff != '0) && ((diff & (diff - One)) == '0);
    adj_d   = have_prev_q && one_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      gray_out    <= '0;
      adj_ok      <= 1'b0;
      sample_cnt  <= '0;
      have_prev_q <= 1'b0;
      prev_gray_q <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gray_out    <= gray_d;
        adj_ok      <= adj_d;
        sample_cnt  <= sample_cnt + One;
        have_prev_q <= 1'b1;
        prev_gray_q <= gray_d;
      end
    end
  end

`ifdef GRAY_DECODE_CHECK_EN
  logic [WIDTH-1:0] dec_bin;

  // Decode the code being registered so the error flag lines up with out_valid.
  always_comb begin
    dec_bin = '0;
    dec_bin[WIDTH-1] = gray_d[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ gray_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decode_err <= 1'b0;
      bin_echo   <= '0;
    end else begin
      decode_err <= in_valid && (dec_bin != bin_in);
      if (in_valid) begin
        bin_echo <= dec_bin;
      end
    end
  end
`else
  // Decoder self-check not built.
`endif

endmodule

// File: tb/tb_binary_to_gray.sv
// Self-checking bench for binary_to_gray: directed test-plan vectors plus random traffic
// checked against a reflected-table Gray model.
module tb_binary_to_gray;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N = 1 << WIDTH;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] bin_in;
  logic             out_valid;
  logic [WIDTH-1:0] gray_out;
  logic             adj_ok;
  logic [WIDTH-1:0] sample_cnt;
`ifdef GRAY_DECODE_CHECK_EN
  logic             decode_err;
  logic [WIDTH-1:0] bin_echo;
`endif

  binary_to_gray #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .bin_in     (bin_in),
    .out_valid  (out_valid),
    .gray_out   (gray_out),
    .adj_ok     (adj_ok),
    .sample_cnt (sample_cnt)
`ifdef GRAY_DECODE_CHECK_EN
    ,
    .decode_err (decode_err),
    .bin_echo   (bin_echo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state
  int unsigned      gray_tab [N];
  logic [WIDTH-1:0] exp_gray;
  logic             exp_valid;
  logic             exp_adj;
  logic [WIDTH-1:0] exp_cnt;
  logic [WIDTH-1:0] exp_bin;
  logic             m_have_prev;
  logic [WIDTH-1:0] m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount(input int unsigned x);
    int n = 0;
    for (int k = 0; k < 32; k++) n += (x >> k) & 1;
    return n;
  endfunction

  task automatic model_reset();
    exp_gray    = '0;
    exp_valid   = 1'b0;
    exp_adj     = 1'b0;
    exp_cnt     = '0;
    exp_bin     = '0;
    m_have_prev = 1'b0;
    m_prev      = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".gray_out"}, 32'(gray_out), 32'(exp_gray));
    check({tag, ".adj_ok"}, 32'(adj_ok), 32'(exp_adj));
    check({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(exp_cnt));
`ifdef GRAY_DECODE_CHECK_EN
    check({tag, ".decode_err"}, 32'(decode_err), 32'(0));
    check({tag, ".bin_echo"}, 32'(bin_echo), 32'(exp_bin));
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    @(negedge clk);
    in_valid = v;
    bin_in   = b;
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v) begin
      g = WIDTH'(gray_tab[b]);
      exp_adj     = m_have_prev && (popcount(32'(g ^ m_prev)) == 1);
      m_have_prev = 1'b1;
      m_prev      = g;
      exp_gray    = g;
      exp_bin     = b;
      exp_cnt     = exp_cnt + 1'b1;
    end
    check_all(tag);
  endtask

  logic [WIDTH-1:0] sweep_exp [N];

  initial begin
    // Reflected-binary construction: mirror the lower half and set the new top bit.
    gray_tab[0] = 0;
    for (int k = 0; k < WIDTH; k++) begin
      for (int j = 0; j < (1 << k); j++) begin
        gray_tab[(1 << k) + j] = gray_tab[(1 << k) - 1 - j] | (1 << k);
      end
    end
    sweep_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    bin_in   = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin
      step("sweep", 1'b1, WIDTH'(i));
      check("sweep.table", 32'(gray_out), 32'(sweep_exp[i]));
    end
    step("wrap", 1'b1, 4'd0);
    check("wrap.adj_lit", 32'(adj_ok), 32'(1));

    step("same_a", 1'b1, 4'd5);
    step("same_b", 1'b1, 4'd5);
    check("same.adj_lit", 32'(adj_ok), 32'(0));
    step("p1a", 1'b1, 4'd3);
    step("p1b", 1'b1, 4'd12);
    step("p2a", 1'b1, 4'd0);
    step("p2b", 1'b1, 4'd3);
    step("p3a", 1'b1, 4'd1);
    step("p3b", 1'b1, 4'd2);
    step("p4a", 1'b1, 4'd0);
    step("p4b", 1'b1, 4'd5);
    check("p4.adj_lit", 32'(adj_ok), 32'(0));

    step("hold0", 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 4'(i + 6));
    check("hold.gray_lit", 32'(gray_out), 32'(4'b1101));

    // Asynchronous reset in the middle of a low clock phase.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_a", 1'b1, 4'd1);
    step("post_rst_b", 1'b1, 4'd3);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), WIDTH'($urandom));
    end

`ifdef GRAY_DECODE_CHECK_EN
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 4'd6;
    force dut.gray_d = 4'b0100;
    @(posedge clk);
    #1;
    release dut.gray_d;
    check("inject.decode_err", 32'(decode_err), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("inject.pulse_end", 32'(decode_err), 32'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
